// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// spi_flash_responder: SPI mode-0 target emulating the read side of an
// SST25-style serial flash. SCK, CS_n and SI are oversampled on i_clk.
// Supported opcodes are READ (opcode + 24-bit address, streaming data) and
// RDSR (status byte, repeated for as long as CS_n stays low).
//
// Ports:
//   i_clk        system clock, at least 8x the SCK frequency
//   i_reset      synchronous reset, active-high
//   i_spi_clk    SCK from the master (asynchronous)
//   i_spi_cs_n   chip select, active-low (asynchronous)
//   i_spi_si     master-out data (asynchronous)
//   o_spi_so     target-out data
//   o_spi_so_en  tri-state enable for o_spi_so
//   o_mem_rd     one-cycle memory read strobe
//   o_mem_addr   memory read address, valid with o_mem_rd
//   i_mem_data   memory read data, valid one i_clk after o_mem_rd
//   i_status     status byte returned by RDSR
//   o_busy       high from CS assertion until the FSM is back in IDLE
//   o_cmd_err    one-cycle pulse on an unsupported opcode
module spi_flash_responder #(
   parameter int unsigned P_ADDR_W   = 17,
   parameter logic [7:0]  P_CMD_READ = 8'h03,
   parameter logic [7:0]  P_CMD_RDSR = 8'h05
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_spi_clk,
   input  logic                i_spi_cs_n,
   input  logic                i_spi_si,
   output logic                o_spi_so,
   output logic                o_spi_so_en,
   output logic                o_mem_rd,
   output logic [P_ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]          i_mem_data,
   input  logic [7:0]          i_status,
   output logic                o_busy,
   output logic                o_cmd_err
);

   // Receive shifter holds the opcode and the low address bits; upper wire
   // address bits simply fall off the top.
   localparam int unsigned RX_W = (P_ADDR_W > 8) ? P_ADDR_W : 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_STAT,
      S_IGNORE
   } state_t;

   state_t              state;
   logic                sck_s1, sck_s2, sck_prev;
   logic                cs_s1, cs_s2;
   logic                si_s1, si_s2;
   logic                sck_rise, sck_fall;
   logic [2:0]          bitcnt;
   logic [1:0]          byte_cnt;
   logic [RX_W-1:0]     rx_sh;
   logic [RX_W-1:0]     rx_next;
   logic [P_ADDR_W-1:0] addr;
   logic [7:0]          prefetch;
   logic [7:0]          out_sh;
   logic                rd_pend;

   assign sck_rise = sck_s2 & ~sck_prev;
   assign sck_fall = ~sck_s2 & sck_prev;
   assign rx_next  = {rx_sh[RX_W-2:0], si_s2};

   // Synchronizers, FSM and all registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sck_s1      <= 1'b0;
         sck_s2      <= 1'b0;
         sck_prev    <= 1'b0;
         cs_s1       <= 1'b1;
         cs_s2       <= 1'b1;
         si_s1       <= 1'b0;
         si_s2       <= 1'b0;
         state       <= S_IDLE;
         bitcnt      <= 3'd0;
         byte_cnt    <= 2'd0;
         rx_sh       <= '0;
         addr        <= '0;
         prefetch    <= 8'd0;
         out_sh      <= 8'd0;
         rd_pend     <= 1'b0;
         o_spi_so    <= 1'b0;
         o_spi_so_en <= 1'b0;
         o_mem_rd    <= 1'b0;
         o_mem_addr  <= '0;
         o_busy      <= 1'b0;
         o_cmd_err   <= 1'b0;
      end else begin
         sck_s1   <= i_spi_clk;
         sck_s2   <= sck_s1;
         sck_prev <= sck_s2;
         cs_s1    <= i_spi_cs_n;
         cs_s2    <= cs_s1;
         si_s1    <= i_spi_si;
         si_s2    <= si_s1;

         o_mem_rd  <= 1'b0;
         o_cmd_err <= 1'b0;

         // Memory data arrives one cycle after the strobe.
         rd_pend <= o_mem_rd;
         if (rd_pend) begin
            prefetch <= i_mem_data;
         end

         // Deselect overrides everything, including a coincident SCK edge.
         if (cs_s2) begin
            state       <= S_IDLE;
            o_spi_so    <= 1'b0;
            o_spi_so_en <= 1'b0;
            o_busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  state    <= S_CMD;
                  bitcnt   <= 3'd0;
                  byte_cnt <= 2'd0;
                  o_busy   <= 1'b1;
               end

               S_CMD: begin
                  if (sck_rise) begin
                     rx_sh  <= rx_next;
                     bitcnt <= bitcnt + 3'd1;
                     if (bitcnt == 3'd7) begin
                        if (rx_next[7:0] == P_CMD_READ) begin
                           state    <= S_ADDR;
                           byte_cnt <= 2'd0;
                        end else if (rx_next[7:0] == P_CMD_RDSR) begin
                           state  <= S_STAT;
                           out_sh <= i_status;
                        end else begin
                           state     <= S_IGNORE;
                           o_cmd_err <= 1'b1;
                        end
                     end
                  end
               end

               S_ADDR: begin
                  if (sck_rise) begin
                     rx_sh  <= rx_next;
                     bitcnt <= bitcnt + 3'd1;
                     if (bitcnt == 3'd7) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) begin
                           addr       <= rx_next[P_ADDR_W-1:0];
                           o_mem_addr <= rx_next[P_ADDR_W-1:0];
                           o_mem_rd   <= 1'b1;
                           state      <= S_DATA;
                        end
                     end
                  end
               end

               S_DATA: begin
                  if (sck_rise) begin
                     bitcnt <= bitcnt + 3'd1;
                  end
                  if (sck_fall) begin
                     if (bitcnt == 3'd0) begin
                        // Byte boundary: emit the prefetched byte and fetch
                        // the next one so it is ready a full byte later.
                        o_spi_so    <= prefetch[7];
                        out_sh      <= {prefetch[6:0], 1'b0};
                        o_spi_so_en <= 1'b1;
                        addr        <= addr + P_ADDR_W'(1);
                        o_mem_addr  <= addr + P_ADDR_W'(1);
                        o_mem_rd    <= 1'b1;
                     end else begin
                        o_spi_so <= out_sh[7];
                        out_sh   <= {out_sh[6:0], 1'b0};
                     end
                  end
               end

               S_STAT: begin
                  if (sck_rise) begin
                     bitcnt <= bitcnt + 3'd1;
                     // Reload on the last rise of each byte so the next byte
                     // reflects the current status.
                     if (bitcnt == 3'd7) begin
                        out_sh <= i_status;
                     end
                  end
                  if (sck_fall) begin
                     o_spi_so    <= out_sh[7];
                     out_sh      <= {out_sh[6:0], 1'b0};
                     o_spi_so_en <= 1'b1;
                  end
               end

               S_IGNORE: begin
                  o_spi_so_en <= 1'b0;
               end

               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
// Bench for spi_flash_responder: directed SPI transactions from a mode-0
// master model; expected SO bytes and memory read addresses go into
// queues that independent monitors drain as the DUT produces them.
module tb_spi_flash_responder;

   localparam int unsigned ADDR_W = 17;

   logic              clk = 1'b0;
   logic              rst;
   logic              sck;
   logic              cs_n;
   logic              si;
   logic              so;
   logic              so_en;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic [7:0]        status;
   logic              busy;
   logic              cmd_err;

   always #5 clk = ~clk;

   spi_flash_responder #(
      .P_ADDR_W  (ADDR_W),
      .P_CMD_READ(8'h03),
      .P_CMD_RDSR(8'h05)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_spi_clk  (sck),
      .i_spi_cs_n (cs_n),
      .i_spi_si   (si),
      .o_spi_so   (so),
      .o_spi_so_en(so_en),
      .o_mem_rd   (mem_rd),
      .o_mem_addr (mem_addr),
      .i_mem_data (mem_data),
      .i_status   (status),
      .o_busy     (busy),
      .o_cmd_err  (cmd_err)
   );

   // Byte-wide memory with one-cycle read latency.
   logic [7:0] mem [0:(1<<ADDR_W)-1];
   initial mem_data = 8'h00;
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   int         n_checks = 0;
   int         n_pass   = 0;
   int         exp_addr[$];
   logic [7:0] exp_so[$];
   bit         mon_en     = 1'b0;
   bit         so_allowed = 1'b0;
   int         so_en_viol = 0;
   int         rd_b2b     = 0;
   int         err_pulses = 0;
   bit         rd_prev    = 1'b0;
   logic [7:0] rx_byte    = 8'h00;
   int         rx_bits    = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // Memory-port / enable / error monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_rd) begin
         if (rd_prev) rd_b2b++;
         if (exp_addr.size() == 0) check("mem_rd_unexpected", int'(mem_addr), -1);
         else check("mem_rd_addr", int'(mem_addr), exp_addr.pop_front());
      end
      rd_prev = mem_rd;
      if (cmd_err) err_pulses++;
      if (so_en && !so_allowed) so_en_viol++;
   end

   // SO monitor: master-side sampling on SCK rise during data phases.
   always @(posedge sck) begin
      if (mon_en) begin
         if (!so_en) so_en_viol++;
         rx_byte = {rx_byte[6:0], so};
         rx_bits++;
         if (rx_bits == 8) begin
            rx_bits = 0;
            if (exp_so.size() == 0) check("so_unexpected", int'(rx_byte), -1);
            else check("so_byte", int'(rx_byte), int'(exp_so.pop_front()));
         end
      end
   end

   // SCK period 80 ns = 8 i_clk; edges land on i_clk falling edges.
   task automatic spi_bits(input logic [7:0] tx, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         si = tx[i];
         #40 sck = 1'b1;
         #40 sck = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx);
      spi_bits(tx, 8);
   endtask

   task automatic cs_low();
      @(negedge clk);
      cs_n = 1'b0;
      #40;
   endtask

   task automatic cs_high();
      #40 cs_n = 1'b1;
      #80;
   endtask

   task automatic read_cmd(input logic [23:0] a);
      spi_byte(8'h03);
      spi_byte(a[23:16]);
      spi_byte(a[15:8]);
      so_allowed = 1'b1;
      spi_byte(a[7:0]);
   endtask

   // Full READ transaction; caller queues the expected addresses and bytes.
   task automatic run_read(input logic [23:0] a, input int nbytes);
      cs_low();
      read_cmd(a);
      rx_bits = 0;
      mon_en  = 1'b1;
      for (int b = 0; b < nbytes; b++) spi_byte(8'h00);
      mon_en = 1'b0;
      check("busy_during_read", int'(busy), 1);
      cs_high();
      so_allowed = 1'b0;
      check("so_en_after_cs", int'(so_en), 0);
      check("busy_after_cs", int'(busy), 0);
      check("so_queue_drained", exp_so.size(), 0);
      check("addr_queue_drained", exp_addr.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int err0;
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; si = 1'b0; status = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_so", int'(so), 0);
      check("rst_so_en", int'(so_en), 0);
      check("rst_mem_rd", int'(mem_rd), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cmd_err", int'(cmd_err), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // READ 0x10: a byte is fetched at every byte boundary, including the
      // final SCK fall, hence four strobes for two data bytes.
      mem[17'h00010] = 8'hA5;
      mem[17'h00011] = 8'h3C;
      exp_addr.push_back('h10); exp_addr.push_back('h11);
      exp_addr.push_back('h12); exp_addr.push_back('h13);
      exp_so.push_back(8'hA5); exp_so.push_back(8'h3C);
      run_read(24'h000010, 2);
      check("so_en_outside_data", so_en_viol, 0);

      // READ at the top of the address space wraps to 0.
      mem[17'h1FFFF] = 8'h11;
      mem[17'h00000] = 8'h22;
      exp_addr.push_back('h1FFFF); exp_addr.push_back('h0);
      exp_addr.push_back('h1);     exp_addr.push_back('h2);
      exp_so.push_back(8'h11); exp_so.push_back(8'h22);
      run_read(24'h01FFFF, 2);

      // RDSR: status changes mid first byte, second byte shows the new value.
      status = 8'h82;
      exp_so.push_back(8'h82); exp_so.push_back(8'h03);
      cs_low();
      so_allowed = 1'b1;
      spi_byte(8'h05);
      rx_bits = 0;
      mon_en  = 1'b1;
      fork begin #480; status = 8'h03; end join_none
      spi_byte(8'h00);
      spi_byte(8'h00);
      mon_en = 1'b0;
      cs_high();
      so_allowed = 1'b0;
      check("rdsr_so_queue_drained", exp_so.size(), 0);
      check("rdsr_so_en_after_cs", int'(so_en), 0);

      // Unsupported opcode.
      err0 = err_pulses;
      cs_low();
      spi_byte(8'h9F);
      spi_byte(8'h00);
      spi_byte(8'h00);
      check("bad_op_busy", int'(busy), 1);
      #40 cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("bad_op_busy_drop_3clk", int'(busy), 0);
      check("bad_op_err_pulses", err_pulses - err0, 1);
      check("bad_op_so_en_viol", so_en_viol, 0);
      #80;

      // Abort after 10 address bits, then a clean READ at 4.
      cs_low();
      spi_byte(8'h03);
      spi_byte(8'h00);
      spi_bits(8'h00, 2);
      cs_high();
      check("abort_busy", int'(busy), 0);
      mem[17'h00004] = 8'h5A;
      exp_addr.push_back('h4); exp_addr.push_back('h5); exp_addr.push_back('h6);
      exp_so.push_back(8'h5A);
      run_read(24'h000004, 1);

      // Reset in the middle of a data byte.
      exp_addr.push_back('h10); exp_addr.push_back('h11);
      cs_low();
      read_cmd(24'h000010);
      spi_bits(8'h00, 3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_so", int'(so), 0);
      check("mid_rst_so_en", int'(so_en), 0);
      check("mid_rst_mem_rd", int'(mem_rd), 0);
      check("mid_rst_mem_addr", int'(mem_addr), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_cmd_err", int'(cmd_err), 0);
      rst = 1'b0;
      so_allowed = 1'b0;
      cs_high();
      exp_addr.push_back('h11); exp_addr.push_back('h12); exp_addr.push_back('h13);
      exp_so.push_back(8'h3C);
      run_read(24'h000011, 1);

      check("mem_rd_back_to_back", rd_b2b, 0);
      check("so_en_viol_total", so_en_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
